// File: rtl/i2c_master_pkg.sv
// Shared command codes, FSM states and quarter-phase constants for the I2C master.
package i2c_master_pkg;

    localparam logic [2:0] CMD_IDLE      = 3'd0;
    localparam logic [2:0] CMD_START     = 3'd1;
    localparam logic [2:0] CMD_WRITE     = 3'd2;
    localparam logic [2:0] CMD_READ      = 3'd3;
    localparam logic [2:0] CMD_READ_ACK  = 3'd4;
    localparam logic [2:0] CMD_READ_NACK = 3'd5;
    localparam logic [2:0] CMD_STOP      = 3'd6;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TX_BITS,
        ST_RX_BITS,
        ST_ACK_SLOT,
        ST_STOP,
        ST_DONE
    } state_e;

    function automatic int quarter_cycles(input int clk_freq, input int i2c_freq);
        return clk_freq / (4 * i2c_freq);
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period divider: one tick every QUARTER enabled cycles; hold freezes the count.
module i2c_quarter_tick #(
    parameter int QUARTER = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

    logic [CW-1:0] cnt;
    logic          step;

    assign step = en && !hold;
    assign tick = step && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_interface.sv
// Command-driven byte-level I2C master; open-drain SDA/SCL driven only low or Z.
module i2c_master_interface
    import i2c_master_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int I2C_FREQ = 400_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    input  logic [2:0] i_cmd,
    input  logic       i_cmd_valid,
    output logic       o_cmd_done,
    output logic       o_cmd_error,
    inout  wire        io_sda,
    inout  wire        io_scl
);
    localparam int QUARTER = quarter_cycles(CLK_FREQ, I2C_FREQ);

    state_e     state, state_next;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [2:0] cmd;
    logic [7:0] shreg;
    logic       sda_low, scl_low, bus_active;
    logic       accept, tick, busy, slot, stretch, cmd_ok, cmd_read, last_q;

    assign io_sda = sda_low ? 1'b0 : 1'bz;
    assign io_scl = scl_low ? 1'b0 : 1'bz;

    assign busy     = state inside {ST_START, ST_TX_BITS, ST_RX_BITS, ST_ACK_SLOT, ST_STOP};
    assign slot     = state inside {ST_TX_BITS, ST_RX_BITS, ST_ACK_SLOT};
    assign cmd_ok   = (i_cmd != CMD_IDLE) && (i_cmd != 3'd7);
    assign cmd_read = cmd inside {CMD_READ, CMD_READ_ACK, CMD_READ_NACK};
    assign last_q   = tick && (phase == Q3);
    // Slave may stretch: the high quarter only starts once SCL actually reads high.
    assign stretch  = slot && (phase == Q2) && !io_scl;

    i2c_quarter_tick #(.QUARTER(QUARTER)) u_tick (
        .clk  (i_clk),
        .rst_n(i_rst),
        .en   (busy),
        .clr  (accept),
        .hold (stretch),
        .tick (tick)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_cmd_valid && cmd_ok) begin
                    accept = 1'b1;
                    case (i_cmd)
                        CMD_START: state_next = ST_START;
                        CMD_WRITE: state_next = bus_active ? ST_TX_BITS : ST_DONE;
                        CMD_STOP:  state_next = bus_active ? ST_STOP : ST_DONE;
                        default:   state_next = bus_active ? ST_RX_BITS : ST_DONE;
                    endcase
                end
            end
            ST_START:               if (last_q) state_next = ST_TX_BITS;
            ST_TX_BITS, ST_RX_BITS: if (last_q && bit_cnt == 3'd7) state_next = ST_ACK_SLOT;
            ST_ACK_SLOT, ST_STOP:   if (last_q) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Line changes are registered on the tick that ends a quarter, so each
    // quarter's line state holds for its whole duration.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            phase       <= Q0;
            bit_cnt     <= '0;
            cmd         <= CMD_IDLE;
            shreg       <= '0;
            rx_data     <= '0;
            sda_low     <= 1'b0;
            scl_low     <= 1'b0;
            bus_active  <= 1'b0;
            o_cmd_done  <= 1'b0;
            o_cmd_error <= 1'b0;
        end else begin
            state      <= state_next;
            o_cmd_done <= (state == ST_DONE);
            if (accept) begin
                cmd         <= i_cmd;
                shreg       <= tx_data;
                phase       <= Q0;
                bit_cnt     <= '0;
                o_cmd_error <= (state_next == ST_DONE);
                case (state_next)
                    ST_START:   sda_low <= 1'b0;
                    ST_TX_BITS: begin scl_low <= 1'b1; sda_low <= ~tx_data[7]; end
                    ST_RX_BITS: begin scl_low <= 1'b1; sda_low <= 1'b0; end
                    ST_STOP:    begin scl_low <= 1'b1; sda_low <= 1'b1; end
                    default: ;
                endcase
            end else if (tick) begin
                phase <= phase + 2'd1;
                case (state)
                    ST_START: begin
                        case (phase)
                            Q0: scl_low <= 1'b0;
                            Q1: sda_low <= 1'b1;
                            Q2: scl_low <= 1'b1;
                            default: begin
                                bus_active <= 1'b1;
                                sda_low    <= ~shreg[7];
                            end
                        endcase
                    end
                    ST_STOP: begin
                        case (phase)
                            Q0: scl_low <= 1'b0;
                            Q1: sda_low <= 1'b0;
                            Q2: ;
                            default: bus_active <= 1'b0;
                        endcase
                    end
                    ST_TX_BITS, ST_RX_BITS, ST_ACK_SLOT: begin
                        case (phase)
                            Q0: ;
                            Q1: scl_low <= 1'b0;
                            Q2: begin
                                if (state == ST_RX_BITS) begin
                                    shreg <= {shreg[6:0], io_sda};
                                    if (bit_cnt == 3'd7) rx_data <= {shreg[6:0], io_sda};
                                end else if (state == ST_ACK_SLOT && !cmd_read) begin
                                    o_cmd_error <= io_sda;
                                end
                            end
                            default: begin
                                // bit_cnt wraps 7 -> 0 on entry to the ack slot
                                scl_low <= 1'b1;
                                bit_cnt <= bit_cnt + 3'd1;
                                if (state == ST_TX_BITS) begin
                                    shreg   <= {shreg[6:0], 1'b0};
                                    sda_low <= (bit_cnt == 3'd7) ? 1'b0 : ~shreg[6];
                                end else if (state == ST_RX_BITS && bit_cnt == 3'd7) begin
                                    sda_low <= (cmd != CMD_READ_NACK);
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_interface.sv
// Directed bench for i2c_master_interface with a behavioural register-pointer slave at 0x29.
module tb_i2c_master_interface;
    import i2c_master_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       done, error;
    wire        sda, scl;
    logic       s_sda_low;

    pullup (sda);
    pullup (scl);
    assign sda = s_sda_low ? 1'b0 : 1'bz;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    i2c_master_interface #(.CLK_FREQ(25_000_000), .I2C_FREQ(400_000)) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .tx_data    (tx_data),
        .rx_data    (rx_data),
        .i_cmd      (cmd),
        .i_cmd_valid(cmd_valid),
        .o_cmd_done (done),
        .o_cmd_error(error),
        .io_sda     (sda),
        .io_scl     (scl)
    );

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    // Slave: first written byte sets the pointer, reads auto-increment it.
    localparam logic [6:0] SLV = 7'h29;
    typedef enum {S_IDLE, S_ADDR, S_WR, S_RD} smode_e;
    smode_e     smode;
    logic [7:0] mem [0:255];
    logic [7:0] sh, rbyte, ptr;
    logic       prev_scl, prev_sda, rw, first_wr, m_nack;
    int         nr, start_cnt, stop_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            smode     <= S_IDLE;
            s_sda_low <= 1'b0;
            nr        <= 0;
            prev_scl  <= 1'b1;
            prev_sda  <= 1'b1;
            ptr       <= 8'h00;
            m_nack    <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h1A] <= 8'hAB; mem[8'h1B] <= 8'hCD; mem[8'h1C] <= 8'h12;
            mem[8'h1D] <= 8'h34; mem[8'h1E] <= 8'h56; mem[8'h1F] <= 8'h78;
        end else begin
            prev_scl <= scl;
            prev_sda <= sda;
            if (prev_scl && scl && prev_sda && !sda) begin
                start_cnt <= start_cnt + 1;
                smode <= S_ADDR; nr <= 0; s_sda_low <= 1'b0;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                stop_cnt <= stop_cnt + 1;
                smode <= S_IDLE; nr <= 0; s_sda_low <= 1'b0;
            end else if (smode != S_IDLE && !prev_scl && scl) begin
                nr <= nr + 1;
                if (nr < 8) sh <= {sh[6:0], sda};
                else if (smode == S_RD) m_nack <= sda;
            end else if (smode != S_IDLE && prev_scl && !scl) begin
                if (nr == 8) begin
                    case (smode)
                        S_ADDR: begin s_sda_low <= (sh[7:1] == SLV); rw <= sh[0]; end
                        S_WR: begin
                            s_sda_low <= 1'b1;
                            first_wr  <= 1'b0;
                            if (first_wr) ptr <= sh;
                            else begin mem[ptr] <= sh; ptr <= ptr + 8'd1; end
                        end
                        default: s_sda_low <= 1'b0;
                    endcase
                end else if (nr == 9) begin
                    nr <= 0;
                    case (smode)
                        S_ADDR: begin
                            if (sh[7:1] != SLV) begin
                                smode <= S_IDLE; s_sda_low <= 1'b0;
                            end else if (rw) begin
                                smode <= S_RD; rbyte <= mem[ptr]; s_sda_low <= !mem[ptr][7];
                            end else begin
                                smode <= S_WR; first_wr <= 1'b1; s_sda_low <= 1'b0;
                            end
                        end
                        S_RD: begin
                            ptr <= ptr + 8'd1;
                            if (!m_nack) begin
                                rbyte     <= mem[8'(ptr + 8'd1)];
                                s_sda_low <= !mem[8'(ptr + 8'd1)][7];
                            end else begin
                                smode <= S_IDLE; s_sda_low <= 1'b0;
                            end
                        end
                        default: s_sda_low <= 1'b0;
                    endcase
                end else if (smode == S_RD && nr >= 1 && nr <= 7) begin
                    s_sda_low <= !rbyte[7 - nr];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] c, input logic [7:0] d,
                       input logic exp_err, input int exp_lat);
        int lat;
        @(negedge clk); cmd = c; tx_data = d; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        lat = 0;
        while (!done && lat < 2000) begin @(negedge clk); lat++; end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {31'd0, error}, {31'd0, exp_err});
        if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic read_reg_ptr();
        run("sel_start", CMD_START, 8'h52, 1'b0, 601);
        run("sel_write", CMD_WRITE, 8'h1A, 1'b0, 541);
        run("rd_start", CMD_START, 8'h53, 1'b0, 601);
    endtask

    initial begin
        int base;
        logic [7:0] burst [6];
        burst = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h56, 8'h78};
        cmd = CMD_IDLE; tx_data = 8'h00; cmd_valid = 1'b0;
        start_cnt = 0; stop_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rx", rx_data, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_err", error, 1'b0);
        chk("rst_sda", sda, 1'b1);
        chk("rst_scl", scl, 1'b1);

        base = done_cnt;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); cmd = (i == 0) ? 3'd0 : 3'd7; cmd_valid = 1'b1;
            @(negedge clk); cmd_valid = 1'b0;
            repeat (10) @(negedge clk);
        end
        chk("ignored_cmds", done_cnt, base);

        // Single register read
        read_reg_ptr();
        run("rd_nack", CMD_READ_NACK, 8'h00, 1'b0, 541);
        chk("rd_data", rx_data, 8'hAB);
        chk("rd_nack_rel", m_nack, 1'b1);
        run("rd_stop", CMD_STOP, 8'h00, 1'b0, 61);
        chk("start_seen", start_cnt, 2);
        chk("stop_seen", stop_cnt, 1);

        // Burst read
        read_reg_ptr();
        for (int i = 0; i < 6; i++) begin
            run("burst", (i < 5) ? CMD_READ_ACK : CMD_READ_NACK, 8'h00, 1'b0, 541);
            chk("burst_data", rx_data, burst[i]);
            chk("burst_ack", m_nack, (i < 5) ? 1'b0 : 1'b1);
        end
        run("burst_stop", CMD_STOP, 8'h00, 1'b0, 61);

        // Direct read continues at pointer 0x20
        run("dir_start", CMD_START, 8'h53, 1'b0, 601);
        run("dir_rd", CMD_READ_NACK, 8'h00, 1'b0, 541);
        chk("dir_data", rx_data, 8'h00);
        run("dir_stop", CMD_STOP, 8'h00, 1'b0, 61);

        // No responder
        run("nack_start", CMD_START, 8'h90, 1'b1, 601);
        repeat (30) @(negedge clk);
        chk("nack_err_held", error, 1'b1);
        chk("nack_scl_low", scl, 1'b0);
        run("nack_stop", CMD_STOP, 8'h00, 1'b0, 61);

        // WRITE with idle bus
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("idle_wr", CMD_WRITE, 8'hAA, 1'b1, 1);
        chk("idle_wr_sda", sda, 1'b1);
        chk("idle_wr_scl", scl, 1'b1);

        // Reset mid-READ
        run("mid_start", CMD_START, 8'h53, 1'b0, 601);
        @(negedge clk); cmd = CMD_READ_ACK; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        repeat (250) @(negedge clk);
        chk("mid_scl_busy", scl, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_sda", sda, 1'b1);
        chk("mid_rst_scl", scl, 1'b1);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_err", error, 1'b0);
        rst_n = 1'b1;
        run("post_start", CMD_START, 8'h52, 1'b0, 601);
        run("post_stop", CMD_STOP, 8'h00, 1'b0, 61);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
